nor_lock_scan: RTL and testbench

- Parametrised successor to the single-block NOR lock-status reader for the Nexys3 parallel NOR flash.
- Scans NUM_BLOCKS consecutive erase blocks from a start block. For each block it issues Read Identifier (0x0090) to the block base, then reads the block lock configuration at base+2.
- Collects a per-block lock map, then returns the flash to Read Array (0x00FF). Exposes a start/busy/done handshake and an 8-bit LED view.

---
 rtl/nor_pkg.sv | 23 ++
 rtl/nor_bus_cycle.sv | 89 ++++++++
 rtl/nor_lock_scan.sv | 152 +++++++++++++++
 tb/tb_nor_lock_scan.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nor_pkg.sv
// Shared constants and scan-FSM state encoding for the NOR lock-status scanner.
package nor_pkg;

  localparam logic [15:0] CMD_READ_ID    = 16'h0090;
  localparam logic [15:0] CMD_READ_ARRAY = 16'h00FF;
  localparam int          LOCK_CFG_OFS   = 2;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WSET,
    S_WLOW,
    S_WHOLD,
    S_WGAP,
    S_RD,
    S_RGAP,
    S_EXIT_SET,
    S_EXIT_LOW,
    S_EXIT_HOLD,
    S_EXIT_GAP,
    S_FIN
  } nor_state_t;

endpackage

// File: rtl/nor_bus_cycle.sv
// Flash pin driver for one write or read cycle: phase strobes, shared WLOW/RD
// timer and the held word address; the scan FSM supplies the current phase.
module nor_bus_cycle
  import nor_pkg::*;
#(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16,
  parameter int WE_CYC = 6,
  parameter int RD_CYC = 12
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  nor_state_t        i_state,
  input  logic              i_go,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] i_dq,
  output logic              o_ack,
  output logic [DATA_W-1:0] o_rdata,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_ce_n,
  output logic              o_we_n,
  output logic              o_oe_n,
  output logic              o_dq_oe,
  output logic [DATA_W-1:0] o_dq_out
);

  localparam int MAXC = (WE_CYC > RD_CYC) ? WE_CYC : RD_CYC;
  localparam int CW   = $clog2(MAXC) + 1;

  logic [CW-1:0]     r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              w_cnt_en;
  logic [CW-1:0]     w_lim;

  always_comb begin
    w_cnt_en = 1'b0;
    w_lim    = CW'(RD_CYC - 1);
    case (i_state)
      S_WLOW, S_EXIT_LOW: begin
        w_cnt_en = 1'b1;
        w_lim    = CW'(WE_CYC - 1);
      end
      S_RD:    w_cnt_en = 1'b1;
      default: ;
    endcase
  end

  assign o_ack = w_cnt_en && (r_cnt == w_lim);

  // Address is loaded on launch and otherwise held, so it stays put through gaps.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_addr <= '0;
    end else begin
      r_cnt <= (w_cnt_en && !o_ack) ? r_cnt + CW'(1) : '0;
      if (i_go) r_addr <= i_addr;
    end
  end

  always_comb begin
    o_ce_n  = 1'b1;
    o_we_n  = 1'b1;
    o_oe_n  = 1'b1;
    o_dq_oe = 1'b0;
    case (i_state)
      S_WSET, S_WHOLD, S_EXIT_SET, S_EXIT_HOLD: begin
        o_ce_n  = 1'b0;
        o_dq_oe = 1'b1;
      end
      S_WLOW, S_EXIT_LOW: begin
        o_ce_n  = 1'b0;
        o_we_n  = 1'b0;
        o_dq_oe = 1'b1;
      end
      S_RD: begin
        o_ce_n = 1'b0;
        o_oe_n = 1'b0;
      end
      default: ;
    endcase
  end

  assign o_dq_out = i_wdata;
  assign o_rdata  = i_dq;
  assign o_addr   = r_addr;

endmodule

// File: rtl/nor_lock_scan.sv
// Scans NUM_BLOCKS erase blocks for lock status, then restores Read Array mode.
// Define NOR_LOCKDOWN_EN to also capture the per-block locked-down bit (DQ1).
module nor_lock_scan
  import nor_pkg::*;
#(
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 16,
  parameter int NUM_BLOCKS = 8,
  parameter int BLK_SHIFT  = 16,
  parameter int WE_CYC     = 6,
  parameter int RD_CYC     = 12
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START,
  input  logic [7:0]            START_BLK,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [NUM_BLOCKS-1:0] LOCK_MAP,
  output logic [NUM_BLOCKS-1:0] LDOWN_MAP,
  output logic [7:0]            SHOW,
  output logic [ADDR_W-1:0]     ADDR,
  inout  wire  [DATA_W-1:0]     DATA,
  output logic                  CE,
  output logic                  WE,
  output logic                  OE
);

  localparam int IW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

  nor_state_t            r_state, w_nxt;
  logic [IW-1:0]         r_idx;
  logic [ADDR_W-1:0]     r_blk;
  logic [NUM_BLOCKS-1:0] r_lock;
  logic                  w_go, w_ack, w_last, w_dq_oe, w_cap;
  logic [ADDR_W-1:0]     w_addr, w_base;
  logic [DATA_W-1:0]     w_wdata, w_rdata, w_dq_out;
  logic                  w_unused;

  assign w_last = (r_idx == IW'(NUM_BLOCKS - 1));
  assign w_base = r_blk << BLK_SHIFT;
  assign w_cap  = (r_state == S_RD) && w_ack;

  always_comb begin
    w_nxt  = r_state;
    w_go   = 1'b0;
    w_addr = w_base;
    case (r_state)
      S_IDLE: if (START) begin
        w_nxt  = S_WSET;
        w_go   = 1'b1;
        w_addr = ADDR_W'(START_BLK) << BLK_SHIFT;
      end
      S_WSET:  w_nxt = S_WLOW;
      S_WLOW:  if (w_ack) w_nxt = S_WHOLD;
      S_WHOLD: w_nxt = S_WGAP;
      S_WGAP: begin
        w_nxt  = S_RD;
        w_go   = 1'b1;
        w_addr = w_base + ADDR_W'(LOCK_CFG_OFS);
      end
      S_RD:    if (w_ack) w_nxt = S_RGAP;
      S_RGAP: begin
        w_go = 1'b1;
        if (w_last) begin
          w_nxt  = S_EXIT_SET;
          w_addr = '0;
        end else begin
          w_nxt  = S_WSET;
          w_addr = (r_blk + ADDR_W'(1)) << BLK_SHIFT;
        end
      end
      S_EXIT_SET:  w_nxt = S_EXIT_LOW;
      S_EXIT_LOW:  if (w_ack) w_nxt = S_EXIT_HOLD;
      S_EXIT_HOLD: w_nxt = S_EXIT_GAP;
      S_EXIT_GAP:  w_nxt = S_FIN;
      default:     w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_blk   <= '0;
      r_lock  <= '0;
    end else begin
      r_state <= w_nxt;
      if (r_state == S_IDLE && START) begin
        r_blk  <= ADDR_W'(START_BLK);
        r_idx  <= '0;
        r_lock <= '0;
      end
      if (r_state == S_RGAP && !w_last) begin
        r_blk <= r_blk + ADDR_W'(1);
        r_idx <= r_idx + IW'(1);
      end
      if (w_cap) r_lock[r_idx] <= w_rdata[0];
    end
  end

`ifdef NOR_LOCKDOWN_EN
  logic [NUM_BLOCKS-1:0] r_ldown;
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)                         r_ldown <= '0;
    else if (r_state == S_IDLE && START) r_ldown <= '0;
    else if (w_cap)                      r_ldown[r_idx] <= w_rdata[1];
  end
  assign LDOWN_MAP = r_ldown;
  assign w_unused  = ^w_rdata[DATA_W-1:2];
`else
  assign LDOWN_MAP = '0;
  assign w_unused  = ^w_rdata[DATA_W-1:1];
`endif

  assign w_wdata = (r_state inside {S_EXIT_SET, S_EXIT_LOW, S_EXIT_HOLD})
                   ? DATA_W'(CMD_READ_ARRAY) : DATA_W'(CMD_READ_ID);

  nor_bus_cycle #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WE_CYC(WE_CYC), .RD_CYC(RD_CYC)
  ) u_bus (
    .i_clk   (CLK),
    .i_rst_n (RESET),
    .i_state (r_state),
    .i_go    (w_go),
    .i_addr  (w_addr),
    .i_wdata (w_wdata),
    .i_dq    (DATA),
    .o_ack   (w_ack),
    .o_rdata (w_rdata),
    .o_addr  (ADDR),
    .o_ce_n  (CE),
    .o_we_n  (WE),
    .o_oe_n  (OE),
    .o_dq_oe (w_dq_oe),
    .o_dq_out(w_dq_out)
  );

  assign DATA     = w_dq_oe ? w_dq_out : {DATA_W{1'bz}};
  assign BUSY     = (r_state != S_IDLE) && (r_state != S_FIN);
  assign DONE     = (r_state == S_FIN);
  assign LOCK_MAP = r_lock;

  generate
    if (NUM_BLOCKS >= 8) begin : g_show_full
      assign SHOW = r_lock[7:0];
    end else begin : g_show_ext
      assign SHOW = {{(8 - NUM_BLOCKS){1'b0}}, r_lock};
    end
  endgenerate

endmodule

// File: tb/tb_nor_lock_scan.sv
// Randomized scoreboard bench for nor_lock_scan against a behavioural flash
// model; expected bus ops and scan results are queued at START and checked by a monitor.
module tb_nor_lock_scan;

  localparam int NB  = 8;
  localparam int AW  = 24;
  localparam int DW  = 16;
  localparam int BS  = 16;
  localparam int WEC = 6;
  localparam int RDC = 12;
  localparam int LAT = NB * (WEC + RDC + 4) + WEC + 3;

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic          START = 1'b0;
  logic [7:0]    START_BLK = 8'h00;
  logic          BUSY, DONE, CE, WE, OE;
  logic [NB-1:0] LOCK_MAP, LDOWN_MAP;
  logic [7:0]    SHOW;
  logic [AW-1:0] ADDR;
  wire  [DW-1:0] DATA;

  nor_lock_scan #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_BLOCKS(NB), .BLK_SHIFT(BS),
    .WE_CYC(WEC), .RD_CYC(RDC)
  ) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .START_BLK(START_BLK),
    .BUSY(BUSY), .DONE(DONE), .LOCK_MAP(LOCK_MAP), .LDOWN_MAP(LDOWN_MAP),
    .SHOW(SHOW), .ADDR(ADDR), .DATA(DATA), .CE(CE), .WE(WE), .OE(OE)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Flash: per-block lock/lock-down bits, identifier mode entered by 0x90, left by 0xFF.
  logic [255:0] lock_v = '0;
  logic [255:0] ldown_v = '0;
  logic         id_mode = 1'b0;
  logic [DW-1:0] flash_q;
  assign flash_q = (id_mode && ADDR[15:0] == 16'd2)
                   ? {14'd0, ldown_v[ADDR[23:16]], lock_v[ADDR[23:16]]} : 16'h5A00;
  assign DATA = (!CE && !OE) ? flash_q : 16'hzzzz;

  always @(posedge WE) begin
    if (DATA == 16'h0090)      id_mode <= 1'b1;
    else if (DATA == 16'h00FF) id_mode <= 1'b0;
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } bus_t;

  typedef struct packed {
    logic [NB-1:0] lock;
    logic [NB-1:0] ldown;
    int            t_acc;
  } res_t;

  bus_t exp_bus[$];
  res_t exp_res[$];
  int   done_cnt = 0;

  // Reference: what the whole scan must look like on the bus and in the maps.
  task automatic push_scan(input int blk, input int t_acc);
    res_t r;
    bus_t b;
    r.lock  = '0;
    r.ldown = '0;
    for (int i = 0; i < NB; i++) begin
      int bi;
      int base;
      bi   = (blk + i) % 256;
      base = ((blk + i) * (1 << BS)) % (1 << AW);
      b.wr = 1'b1; b.addr = AW'(base); b.data = 16'h0090;
      exp_bus.push_back(b);
      b.wr = 1'b0; b.addr = AW'((base + 2) % (1 << AW)); b.data = 16'h0000;
      exp_bus.push_back(b);
      r.lock[i] = lock_v[bi];
`ifdef NOR_LOCKDOWN_EN
      r.ldown[i] = ldown_v[bi];
`endif
    end
    b.wr = 1'b1; b.addr = '0; b.data = 16'h00FF;
    exp_bus.push_back(b);
    r.t_acc = t_acc;
    exp_res.push_back(r);
  endtask

  // Called at posedge+2; START is accepted on the next edge.
  task automatic start_scan(input int blk);
    START_BLK = 8'(blk);
    START = 1'b1;
    push_scan(blk, cyc + 1);
    @(posedge CLK); #2;
    START = 1'b0;
  endtask

  task automatic wait_done(input int n_before);
    int k;
    k = 0;
    while (done_cnt == n_before && k < 400) begin
      @(posedge CLK);
      k++;
    end
    if (done_cnt == n_before) begin
      total++;
      bad++;
      $display("FAIL done_timeout: no DONE after %0d cycles", k);
    end
    @(posedge CLK); #2;
  endtask

  task automatic rand_flash();
    for (int i = 0; i < 256; i++) begin
      lock_v[i]  = 1'($urandom_range(0, 1));
      ldown_v[i] = 1'($urandom_range(0, 1));
    end
  endtask

  // Monitor
  int   wlen = 0;
  int   rlen = 0;
  int   bcnt = 0;
  logic pwe = 1'b1;
  logic poe = 1'b1;
  bus_t mb;
  res_t mr;

  always @(negedge CLK) begin
    if (!RESET) begin
      pwe = 1'b1; poe = 1'b1; wlen = 0; rlen = 0; bcnt = 0;
    end else begin
      chk("we_oe_both_low", 64'({WE, OE} == 2'b00), 64'd0);
      if (!WE) wlen++;
      if (!OE) rlen++;
      if (!pwe && WE) begin
        if (exp_bus.size() == 0) begin
          total++; bad++;
          $display("FAIL bus_extra_write: addr %0h data %0h", ADDR, DATA);
        end else begin
          mb = exp_bus.pop_front();
          chk("bus_write", 64'({1'b1, ADDR, DATA}), 64'(mb));
          chk("we_low_len", 64'(wlen), 64'(WEC));
        end
        wlen = 0;
      end
      if (!poe && OE) begin
        if (exp_bus.size() == 0) begin
          total++; bad++;
          $display("FAIL bus_extra_read: addr %0h", ADDR);
        end else begin
          mb = exp_bus.pop_front();
          chk("bus_read", 64'({1'b0, ADDR, 16'h0000}), 64'(mb));
          chk("oe_low_len", 64'(rlen), 64'(RDC));
        end
        rlen = 0;
      end
      if (BUSY) bcnt++;
      if (DONE) begin
        done_cnt++;
        if (exp_res.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_done: at cycle %0d", cyc);
        end else begin
          mr = exp_res.pop_front();
          chk("lock_map", 64'(LOCK_MAP), 64'(mr.lock));
          chk("ldown_map", 64'(LDOWN_MAP), 64'(mr.ldown));
          chk("show", 64'(SHOW), 64'(mr.lock[7:0]));
          chk("done_latency", 64'(cyc - mr.t_acc), 64'(LAT));
          chk("busy_cycles", 64'(bcnt), 64'(LAT));
          chk("bus_drained", 64'(exp_bus.size()), 64'd0);
          chk("flash_read_array", 64'(id_mode), 64'd0);
        end
        bcnt = 0;
      end
      pwe = WE;
      poe = OE;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(posedge CLK);
    #2;
    chk("rst_pins", 64'({CE, WE, OE, BUSY, DONE}), 64'(5'b11100));
    chk("rst_addr", 64'(ADDR), 64'd0);
    chk("rst_maps", 64'({LOCK_MAP, LDOWN_MAP}), 64'd0);
    RESET = 1'b1;
    repeat (100) begin
      @(posedge CLK); #2;
      chk("idle_pins", 64'({CE, WE, OE, BUSY, SHOW}), 64'({3'b111, 1'b0, 8'h00}));
    end

    // Known pattern from block 0
    lock_v[7:0] = 8'hA5;
    ldown_v[3]  = 1'b1;
    n = done_cnt;
    start_scan(0);
    wait_done(n);
    chk("a5_show", 64'(SHOW), 64'(8'hA5));
`ifdef NOR_LOCKDOWN_EN
    chk("a5_ldown", 64'(LDOWN_MAP), 64'(8'h08));
`else
    chk("a5_ldown", 64'(LDOWN_MAP), 64'd0);
`endif

    // Address wrap past the top of the array
    rand_flash();
    n = done_cnt;
    start_scan(8'hFE);
    wait_done(n);

    // Spurious START mid-scan
    rand_flash();
    n = done_cnt;
    start_scan(int'($urandom_range(0, 255)));
    repeat (48) @(posedge CLK);
    #2;
    START_BLK = 8'($urandom_range(0, 255));
    START = 1'b1;
    @(posedge CLK); #2;
    START = 1'b0;
    wait_done(n);
    repeat (200) @(posedge CLK);
    #2;
    chk("spurious_single_done", 64'(done_cnt), 64'(n + 1));
    chk("spurious_idle", 64'(BUSY), 64'd0);

    // Reset mid-scan
    rand_flash();
    n = done_cnt;
    start_scan(int'($urandom_range(0, 255)));
    repeat (69) @(posedge CLK);
    #2;
    RESET = 1'b0;
    #1;
    chk("midrst_pins", 64'({CE, WE, OE, BUSY, DONE}), 64'(5'b11100));
    chk("midrst_addr", 64'(ADDR), 64'd0);
    chk("midrst_maps", 64'({LOCK_MAP, LDOWN_MAP}), 64'd0);
    exp_bus.delete();
    exp_res.delete();
    repeat (3) @(posedge CLK);
    #2;
    RESET = 1'b1;
    @(posedge CLK); #2;
    chk("midrst_no_done", 64'(done_cnt), 64'(n));
    n = done_cnt;
    start_scan(int'($urandom_range(0, 255)));
    wait_done(n);

    // Random scans
    for (int t = 0; t < 4; t++) begin
      rand_flash();
      n = done_cnt;
      start_scan(int'($urandom_range(0, 255)));
      wait_done(n);
    end

    repeat (5) @(posedge CLK);
    #2;
    chk("queues_empty", 64'(exp_bus.size() + exp_res.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
